uart_tx_arbiter: RTL and testbench

//  - Shares the single UART TX FIFO write port (tx_fifo_write / tx_data) among NUM_REQ byte-stream requesters.
//  - Grants are round-robin, with burst lock: a grant is held until the requester marks its last byte or MAX_BURST bytes are accepted.
//  - Sits between on-chip producers (core shim, debug/console, DMA) and the uart_regs/FIFO write side.

---
 rtl/uart_tx_arbiter_pkg.sv | 8 +
 rtl/uart_rr_picker.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 84 ++++++++
 tb/tb_uart_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types and limits for the UART TX write-port arbiter.
package uart_tx_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} type_uart_arb_state_e;

    localparam int UART_ARB_MAX_REQ = 8;

endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational round-robin scan, first valid index at or after ptr (mod N).
module uart_rr_picker #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        logic [W-1:0] c;
        found = 1'b0;
        idx = '0;
        c = '0;
        // Scan from the farthest offset down so the nearest valid index wins.
        for (int i = N - 1; i >= 0; i--) begin
            c = W'((int'(ptr) + i) % N);
            if (valid[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locked sharing of the UART TX FIFO write port.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_BURST = 8,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arb_en_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 tx_fifo_full_i,
    output logic                 tx_fifo_write_o,
    output logic [7:0]           tx_data_o,
    output logic [ID_W-1:0]      grant_id_o,
    output logic                 busy_o
);

    if (NUM_REQ < 2 || NUM_REQ > UART_ARB_MAX_REQ) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ out of range");
    end

    type_uart_arb_state_e state, state_nx;
    logic [ID_W-1:0] rr_ptr, pick;
    logic [7:0] burst_cnt;
    logic [7:0] req_bytes [NUM_REQ];
    logic found, start, accept, grant_end;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_byte
        assign req_bytes[k] = req_data_i[8*k +: 8];
    end

    uart_rr_picker #(.N(NUM_REQ)) u_picker (
        .valid (req_valid_i),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    // Full lags a write by one cycle, so a write in flight also blocks ready.
    assign req_ready_o = (state == ARB_GRANT && !tx_fifo_full_i && !tx_fifo_write_o)
                         ? NUM_REQ'(1) << grant_id_o : '0;
    assign accept = |(req_valid_i & req_ready_o);
    assign grant_end = accept && (req_last_i[grant_id_o] || burst_cnt == 8'(MAX_BURST - 1));
    assign start = state == ARB_IDLE && arb_en_i && found;
    assign busy_o = state == ARB_GRANT;

    always_comb begin
        state_nx = state;
        if (start)
            state_nx = ARB_GRANT;
        else if (grant_end)
            state_nx = ARB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            rr_ptr <= '0;
            burst_cnt <= '0;
            tx_fifo_write_o <= 1'b0;
            tx_data_o <= 8'h00;
            grant_id_o <= '0;
        end else begin
            state <= state_nx;
            tx_fifo_write_o <= accept;
            if (accept)
                tx_data_o <= req_bytes[grant_id_o];
            if (start) begin
                grant_id_o <= pick;
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (grant_end)
                rr_ptr <= (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-fed requesters, expected-write scoreboard and a decoupled write monitor.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arb_en_i = 1'b1;
    logic tx_fifo_full_i = 1'b0;
    logic [3:0] req_valid_i = '0;
    logic [3:0] req_last_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0] req_ready_o;
    logic tx_fifo_write_o;
    logic [7:0] tx_data_o;
    logic [1:0] grant_id_o;
    logic busy_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit rnd = 1'b0;
    bit rnd_chk = 1'b0;
    logic [3:0] acc_prev = '0;
    logic [8:0] src_q [4][$];
    logic [9:0] exp_g [$];
    logic [7:0] exp_r [4][$];
    int wr_t [$];

    uart_tx_arbiter #(.NUM_REQ(4), .MAX_BURST(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .arb_en_i        (arb_en_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_last_i      (req_last_i),
        .req_ready_o     (req_ready_o),
        .tx_fifo_full_i  (tx_fifo_full_i),
        .tx_fifo_write_o (tx_fifo_write_o),
        .tx_data_o       (tx_data_o),
        .grant_id_o      (grant_id_o),
        .busy_o          (busy_o)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int k, input logic [7:0] d, input bit last);
        src_q[k].push_back({last, d});
    endtask

    task automatic expect_wr(input int k, input logic [7:0] d);
        exp_g.push_back({2'(k), d});
    endtask

    function automatic bit quiet();
        bit q = exp_g.size() == 0;
        for (int k = 0; k < 4; k++)
            q = q && src_q[k].size() == 0 && exp_r[k].size() == 0;
        return q;
    endfunction

    task automatic drain(input string name, input int lim);
        int n = 0;
        while (n < lim && !(quiet() && !busy_o && !tx_fifo_write_o)) begin
            @(negedge clk);
            n++;
        end
        chk(name, quiet() && !busy_o && !tx_fifo_write_o, 1);
    endtask

    task automatic wait_busy(input string name, input int lim);
        int n = 0;
        while (n < lim && !busy_o) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy_o, 1);
    endtask

    // Requester model: present the queue head, pop it when valid & ready just before the edge.
    initial begin
        bit have;
        logic [8:0] f;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                have = src_q[k].size() != 0;
                f = have ? src_q[k][0] : 9'h0;
                req_valid_i[k] = have && (!rnd || $urandom_range(0, 3) != 0);
                req_last_i[k] = f[8];
                req_data_i[8*k +: 8] = f[7:0];
            end
            #4;
            acc_prev = req_valid_i & req_ready_o;
            for (int k = 0; k < 4; k++)
                if (acc_prev[k])
                    void'(src_q[k].pop_front());
        end
    end

    // Write monitor: every write must follow an accept and match the scoreboard head.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("write_vs_accept", tx_fifo_write_o, acc_prev != 0);
                if (tx_fifo_write_o) begin
                    wr_t.push_back(cyc);
                    if (rnd_chk ? exp_r[grant_id_o].size() == 0 : exp_g.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write id=%0d data=%0h want=none", grant_id_o, tx_data_o);
                    end else if (rnd_chk) begin
                        chk("rnd_byte", tx_data_o, exp_r[grant_id_o].pop_front());
                    end else begin
                        e = exp_g.pop_front();
                        chk("wr_id", grant_id_o, e[9:8]);
                        chk("wr_data", tx_data_o, e[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int len;
        // Reset with every requester valid; first grant goes to 0, then 1, 2, 3.
        for (int k = 0; k < 4; k++) begin
            load(k, 8'hA0 + 8'(k), 1'b1);
            expect_wr(k, 8'hA0 + 8'(k));
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready_o, 4'b0000);
        chk("rst_write", tx_fifo_write_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_id_o, 0);
        chk("rst_data", tx_data_o, 8'h00);
        rst = 1'b0;
        #1;
        chk("idle_ready", req_ready_o, 4'b0000);
        @(negedge clk);
        chk("first_busy", busy_o, 1);
        chk("first_grant", grant_id_o, 0);
        chk("first_ready", req_ready_o, 4'b0001);
        drain("t1_drain", 100);

        // Single stream: three bytes, one write every two cycles.
        wr_t.delete();
        load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b0); load(0, 8'h43, 1'b1);
        expect_wr(0, 8'h41); expect_wr(0, 8'h42); expect_wr(0, 8'h43);
        drain("t2_drain", 100);
        chk("t2_writes", wr_t.size(), 3);
        if (wr_t.size() == 3) begin
            chk("t2_gap0", wr_t[1] - wr_t[0], 2);
            chk("t2_gap1", wr_t[2] - wr_t[1], 2);
        end
        // rr_ptr is now 1, so requester 1 beats requester 0.
        load(0, 8'h60, 1'b1); load(1, 8'h61, 1'b1);
        expect_wr(1, 8'h61); expect_wr(0, 8'h60);
        drain("rr1_drain", 100);
        load(3, 8'h62, 1'b1);
        expect_wr(3, 8'h62);
        drain("rr3_drain", 100);

        // rr_ptr = 0 with 0, 2, 3 valid: order 0, 2, 3, 0.
        load(0, 8'h70, 1'b1); load(0, 8'h71, 1'b1); load(2, 8'h72, 1'b1); load(3, 8'h73, 1'b1);
        expect_wr(0, 8'h70); expect_wr(2, 8'h72); expect_wr(3, 8'h73); expect_wr(0, 8'h71);
        drain("t3_drain", 100);

        // Burst limit: 8 bytes from 1, then 2, then 1 resumes.
        for (int j = 0; j < 10; j++)
            load(1, 8'h10 + 8'(j), 1'b0);
        load(2, 8'h20, 1'b1);
        for (int j = 0; j < 8; j++)
            expect_wr(1, 8'h10 + 8'(j));
        expect_wr(2, 8'h20);
        expect_wr(1, 8'h18); expect_wr(1, 8'h19);
        len = 0;
        while (len < 200 && !(exp_g.size() == 0 && src_q[1].size() == 0 && !tx_fifo_write_o)) begin
            @(negedge clk);
            len++;
        end
        chk("t4_burst_done", exp_g.size(), 0);
        // Requester 1 still owns the grant with valid low; requester 2 must wait.
        expect_wr(1, 8'h1A); expect_wr(2, 8'h21);
        load(2, 8'h21, 1'b1);
        repeat (6) @(negedge clk);
        chk("hold_busy", busy_o, 1);
        chk("hold_grant", grant_id_o, 1);
        chk("hold_ready2", req_ready_o[2], 0);
        chk("hold_write", tx_fifo_write_o, 0);
        load(1, 8'h1A, 1'b1);
        drain("t4_drain", 100);

        // FIFO full mid-grant: no ready, no write, then each byte written once.
        tx_fifo_full_i = 1'b1;
        load(3, 8'h30, 1'b0); load(3, 8'h31, 1'b1);
        expect_wr(3, 8'h30); expect_wr(3, 8'h31);
        wait_busy("t5_busy", 20);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("full_ready", req_ready_o, 4'b0000);
            chk("full_write", tx_fifo_write_o, 0);
        end
        chk("full_held", busy_o && grant_id_o == 2'd3, 1);
        tx_fifo_full_i = 1'b0;
        drain("t5_drain", 100);

        // arb_en_i drops mid-grant: message completes, no new grant until re-enabled.
        load(0, 8'h40, 1'b0); load(0, 8'h41, 1'b0); load(0, 8'h42, 1'b1); load(1, 8'h50, 1'b1);
        expect_wr(0, 8'h40); expect_wr(0, 8'h41); expect_wr(0, 8'h42); expect_wr(1, 8'h50);
        wait_busy("t6_busy", 20);
        arb_en_i = 1'b0;
        len = 0;
        while (len < 100 && src_q[0].size() != 0) begin
            @(negedge clk);
            len++;
        end
        chk("t6_msg_done", src_q[0].size(), 0);
        repeat (6) @(negedge clk);
        chk("en_idle_busy", busy_o, 0);
        chk("en_held", src_q[1].size(), 1);
        arb_en_i = 1'b1;
        drain("t6_drain", 100);

        // Random traffic with per-requester ordering.
        rnd = 1'b1;
        rnd_chk = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            tx_fifo_full_i = $urandom_range(0, 2) == 0;
            arb_en_i = $urandom_range(0, 7) != 0;
            for (int k = 0; k < 4; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 12);
                    for (int j = 0; j < len; j++) begin
                        d = 8'($urandom);
                        load(k, d, j == len - 1);
                        exp_r[k].push_back(d);
                    end
                end
            end
        end
        rnd = 1'b0;
        tx_fifo_full_i = 1'b0;
        arb_en_i = 1'b1;
        drain("rnd_drain", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
